// File: rtl/rtype_sequencer_if.sv
// Instruction handshake plus datapath control bundle for rtype_sequencer.
// master = instruction source / datapath side, slave = the sequencer.
interface rtype_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [3:0]  alu_ctrl;
  logic        reg_we;
  logic        zero_flag;
  logic        done;
  logic        done_zero;
  logic        illegal;

  modport master (
    output instr_valid, instr, zero_flag,
    input  instr_ready, rs1_addr, rs2_addr, rd_addr, alu_ctrl, reg_we, done, done_zero, illegal
  );

  modport slave (
    input  instr_valid, instr, zero_flag,
    output instr_ready, rs1_addr, rs2_addr, rd_addr, alu_ctrl, reg_we, done, done_zero, illegal
  );
endinterface

// File: rtl/rtype_sequencer.sv
// R-type sequencer: IDLE->DECODE->EXEC->WB, done 4 cycles after accept, ready only in IDLE.
// Optional retired/illegal counters under RSEQ_PERF_CNT_EN.
module rtype_sequencer #(
  parameter logic [6:0] OPCODE_R = 7'b0110011,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  rtype_sequencer_if.slave bus,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [3:0]  alu_q, alu_d;
  logic        reg_we_q, reg_we_d;
  logic        done_q, done_d;
  logic        done_zero_q, done_zero_d;
  logic        illegal_q, illegal_d;
  logic        instr_ready_q, instr_ready_d;

  logic        legal;
  logic [3:0]  alu_dec;
  logic [6:0]  funct7;
  logic [2:0]  funct3;

  // funct7[5] selects SUB/SRA; other funct7 bits are screened by the legality check
  always_comb begin
    funct7  = instr_q[31:25];
    funct3  = instr_q[14:12];
    alu_dec = 4'b0010;
    case ({instr_q[30], funct3})
      4'b0_000: alu_dec = 4'b0010;
      4'b1_000: alu_dec = 4'b0110;
      4'b0_001: alu_dec = 4'b1000;
      4'b0_010: alu_dec = 4'b0111;
      4'b0_011: alu_dec = 4'b1011;
      4'b0_100: alu_dec = 4'b0011;
      4'b0_101: alu_dec = 4'b1001;
      4'b1_101: alu_dec = 4'b1010;
      4'b0_110: alu_dec = 4'b0001;
      4'b0_111: alu_dec = 4'b0000;
      default:  alu_dec = 4'b0010;
    endcase
    legal = (instr_q[6:0] == OPCODE_R) &&
            ((funct7 == 7'b0000000) ||
             ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    alu_d         = alu_q;
    reg_we_d      = 1'b0;
    done_d        = 1'b0;
    illegal_d     = 1'b0;
    done_zero_d   = done_zero_q;
    instr_ready_d = instr_ready_q;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid && instr_ready_q) begin
          instr_d       = bus.instr;
          instr_ready_d = 1'b0;
          state_d       = DECODE;
        end
      end
      DECODE: begin
        rs1_d = instr_q[19:15];
        rs2_d = instr_q[24:20];
        rd_d  = instr_q[11:7];
        if (legal) begin
          alu_d   = alu_dec;
          state_d = EXEC;
        end else begin
          illegal_d     = 1'b1;
          instr_ready_d = 1'b1;
          state_d       = IDLE;
        end
      end
      EXEC: begin
        done_zero_d = bus.zero_flag;
        reg_we_d    = (rd_q != 5'd0);
        state_d     = WB;
      end
      WB: begin
        done_d        = 1'b1;
        instr_ready_d = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        instr_ready_d = 1'b1;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      alu_q         <= '0;
      reg_we_q      <= 1'b0;
      done_q        <= 1'b0;
      done_zero_q   <= 1'b0;
      illegal_q     <= 1'b0;
      instr_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      alu_q         <= alu_d;
      reg_we_q      <= reg_we_d;
      done_q        <= done_d;
      done_zero_q   <= done_zero_d;
      illegal_q     <= illegal_d;
      instr_ready_q <= instr_ready_d;
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.rs1_addr    = rs1_q;
  assign bus.rs2_addr    = rs2_q;
  assign bus.rd_addr     = rd_q;
  assign bus.alu_ctrl    = alu_q;
  assign bus.reg_we      = reg_we_q;
  assign bus.done        = done_q;
  assign bus.done_zero   = done_zero_q;
  assign bus.illegal     = illegal_q;

`ifdef RSEQ_PERF_CNT_EN
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  // Counted alongside the pulse so the count already includes the event being reported
  always_comb begin
    retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, done_d};
    illegal_cnt_d = illegal_cnt_q + {{(CNT_W-1){1'b0}}, illegal_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`else
  assign retired_cnt = '0;
  assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_rtype_sequencer.sv
// Scoreboard bench for rtype_sequencer: directed cases followed by random instructions.
module tb_rtype_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] retired_cnt, illegal_cnt;

  always #5 clk = ~clk;

  rtype_sequencer_if bus ();

  rtype_sequencer #(.OPCODE_R(7'b0110011), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .retired_cnt (retired_cnt),
    .illegal_cnt (illegal_cnt)
  );

  typedef struct {
    logic [31:0] w;
    bit          legal;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    int          acc;
  } exp_t;

  // Legal R-type (funct7, funct3) pairs and their ALU codes: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
  logic [6:0] tab_f7  [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
  logic [2:0] tab_f3  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
  logic [3:0] tab_alu [10] = '{4'b0010, 4'b0110, 4'b1000, 4'b0111, 4'b1011,
                               4'b0011, 4'b1001, 4'b1010, 4'b0001, 4'b0000};

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   m_ret = 0;
  int   m_ill = 0;
  bit   mon_en = 1'b0;
  bit   zf_force = 1'b0;
  bit   zf_log [8192];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input int acc);
    exp_t e;
    e.w = w; e.acc = acc; e.legal = 1'b0; e.alu = 4'd0;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    if (w[6:0] == 7'h33) begin
      for (int i = 0; i < 10; i++) begin
        if (w[31:25] == tab_f7[i] && w[14:12] == tab_f3[i]) begin
          e.legal = 1'b1;
          e.alu   = tab_alu[i];
        end
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: ;
      1, 2: begin
        w[6:0]   = 7'h33;
        w[31:25] = 7'($urandom);
      end
      default: begin
        w[6:0]   = 7'h33;
        w[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
      end
    endcase
    return w;
  endfunction

  // Called just after a rising edge; returns the cycle in which the handshake completed
  task automatic send(input logic [31:0] w, output int acc);
    int   t;
    exp_t e;
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    t   = 0;
    acc = -1;
    @(negedge clk);
    while (bus.instr_ready !== 1'b1 && t < 20) begin
      t++;
      @(negedge clk);
    end
    if (bus.instr_ready !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: instr_ready=%b after 20 cycles, required 1", bus.instr_ready);
      return;
    end
    acc = cyc;
    e   = model(w, cyc);
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    bus.instr_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.zero_flag = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.zero_flag = zf_force ? 1'b1 : 1'($urandom);
    end
  end

  // Monitor: every cycle the outputs are compared against the head of the scoreboard
  always @(negedge clk) begin
    exp_t h;
    bit   have;
    int   lat;
    zf_log[cyc % 8192] = bus.zero_flag;
    if (mon_en) begin
      have = (q.size() != 0);
      lat  = 0;
      h    = '{default: '0};
      if (have) begin
        h   = q[0];
        lat = h.legal ? 4 : 2;
      end
      chk("instr_ready", 32'(bus.instr_ready), 32'(!have || cyc == h.acc + lat));
      chk("done",        32'(bus.done),        32'(have && h.legal && cyc == h.acc + 4));
      chk("illegal",     32'(bus.illegal),     32'(have && !h.legal && cyc == h.acc + 2));
      chk("reg_we",      32'(bus.reg_we),      32'(have && h.legal && cyc == h.acc + 3 && h.rd != 5'd0));
      if (have && cyc == h.acc + lat) begin
        if (h.legal) begin
          m_ret++;
          chk("rs1_addr",  32'(bus.rs1_addr),  32'(h.rs1));
          chk("rs2_addr",  32'(bus.rs2_addr),  32'(h.rs2));
          chk("rd_addr",   32'(bus.rd_addr),   32'(h.rd));
          chk("alu_ctrl",  32'(bus.alu_ctrl),  32'(h.alu));
          chk("done_zero", 32'(bus.done_zero), 32'(zf_log[(h.acc + 2) % 8192]));
        end else begin
          m_ill++;
        end
`ifdef RSEQ_PERF_CNT_EN
        chk("retired_cnt", retired_cnt, 32'(m_ret));
        chk("illegal_cnt", illegal_cnt, 32'(m_ill));
`else
        chk("retired_cnt", retired_cnt, 32'd0);
        chk("illegal_cnt", illegal_cnt, 32'd0);
`endif
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int a0, a1, a2, t;
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_done",        32'(bus.done),        32'd0);
    chk("rst_illegal",     32'(bus.illegal),     32'd0);
    chk("rst_reg_we",      32'(bus.reg_we),      32'd0);
    chk("rst_rs1",         32'(bus.rs1_addr),    32'd0);
    chk("rst_rd",          32'(bus.rd_addr),     32'd0);
    chk("rst_alu",         32'(bus.alu_ctrl),    32'd0);
    chk("rst_done_zero",   32'(bus.done_zero),   32'd0);
    chk("rst_retired_cnt", retired_cnt,          32'd0);
    chk("rst_illegal_cnt", illegal_cnt,          32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // ADD x3,x1,x2 interrupted by reset while in EXEC
    bus.instr       = 32'h002081B3;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_instr_ready", 32'(bus.instr_ready), 32'd1);
    chk("midrst_reg_we",      32'(bus.reg_we),      32'd0);
    chk("midrst_done",        32'(bus.done),        32'd0);
    chk("midrst_rd",          32'(bus.rd_addr),     32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_write", 32'(bus.reg_we), 32'd0);
      chk("midrst_no_done",  32'(bus.done),   32'd0);
    end
    @(posedge clk);
    #1 mon_en = 1'b1;

    send(32'h002081B3, a0);
    idle(2);
    zf_force = 1'b1;
    send(32'h406302B3, a0);
    idle(6);
    zf_force = 1'b0;
    send(32'h00208033, a0);
    idle(1);
    send(32'h00108093, a0);
    send(32'h4000F1B3, a0);
    idle(3);

    // Valid held high across three instructions
    send(32'h002081B3, a0);
    send(32'h406302B3, a1);
    send(32'h0020F233, a2);
    chk("b2b_spacing_1", 32'(a1 - a0), 32'd4);
    chk("b2b_spacing_2", 32'(a2 - a1), 32'd4);
    idle(2);

    for (int i = 0; i < 200; i++) begin
      send(rand_instr(), a0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    bus.instr_valid = 1'b0;

    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d instructions outstanding, required 0", q.size());
    end
    @(posedge clk);
    #1;
`ifdef RSEQ_PERF_CNT_EN
    chk("final_retired_cnt", retired_cnt, 32'(m_ret));
    chk("final_illegal_cnt", illegal_cnt, 32'(m_ill));
`else
    chk("final_retired_cnt", retired_cnt, 32'd0);
    chk("final_illegal_cnt", illegal_cnt, 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
